// File: rtl/rv32i_alu.sv
// rv32i_alu: RV32I integer ALU with a combinational result/zero flag and a
// one-cycle registered copy of both for pipeline use.
module rv32i_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] in_0,
    input  logic [XLEN-1:0] in_1,
    input  logic [3:0]      operation,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic [XLEN-1:0] out_q,
    output logic            zero_q
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_OR     = 4'h3,
        OP_AND    = 4'h4,
        OP_LSR    = 4'h5,
        OP_LSL    = 4'h6,
        OP_ASR    = 4'h7,
        OP_PASS_1 = 4'h8,
        OP_SLT    = 4'h9,
        OP_SLTU   = 4'hA
    } alu_op_e;

    // Only the low SHW bits of operand B select the shift distance.
    logic [SHW-1:0] shamt;
    assign shamt = in_1[SHW-1:0];

    // Result select; reserved codes fall through to the zero default.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for unlisted or reserved codes.
        out = '0;
        case (operation)
            OP_ADD:    out = in_0 + in_1;
            OP_SUB:    out = in_0 - in_1;
            OP_XOR:    out = in_0 ^ in_1;
            OP_OR:     out = in_0 | in_1;
            OP_AND:    out = in_0 & in_1;
            OP_LSR:    out = in_0 >> shamt;
            OP_LSL:    out = in_0 << shamt;
            OP_ASR:    out = $signed(in_0) >>> shamt;
            OP_PASS_1: out = in_1;
            OP_SLT:    out = {{(XLEN-1){1'b0}}, ($signed(in_0) < $signed(in_1))};
            OP_SLTU:   out = {{(XLEN-1){1'b0}}, (in_0 < in_1)};
            default:   out = '0;
        endcase
    end

    assign zero = (out == '0);

    // Pipeline copy of result and flag; reset leaves a consistent zero pair.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= out;
            zero_q <= zero;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// tb_rv32i_alu: directed vectors with literal expectations plus a
// behavioural reference model checked against the DUT every cycle.
module tb_rv32i_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic [3:0]  operation;
    logic [31:0] out;
    logic        zero;
    logic [31:0] out_q;
    logic        zero_q;

    int n_checks = 0;
    int n_fails  = 0;

    rv32i_alu #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_0      (in_0),
        .in_1      (in_1),
        .operation (operation),
        .out       (out),
        .zero      (zero),
        .out_q     (out_q),
        .zero_q    (zero_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: arithmetic meaning of each operation, not bit tricks.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned ua  = {32'b0, a};
        longint unsigned ub  = {32'b0, b};
        longint unsigned pw  = 64'd1 << (b % 32);
        longint          sa  = longint'(int'(a));
        longint          spw = longint'(pw);
        longint          q;
        longint unsigned r;
        int              ia  = int'(a);
        int              ib  = int'(b);
        case (op)
            4'h0: r = (ua + ub) % (64'd1 << 32);
            4'h1: r = (ua + (64'd1 << 32) - ub) % (64'd1 << 32);
            4'h2: r = ua ^ ub;
            4'h3: r = ua | ub;
            4'h4: r = ua & ub;
            4'h5: r = ua / pw;
            4'h6: r = (ua * pw) % (64'd1 << 32);
            4'h7: begin
                if (sa >= 0) q = sa / spw;
                else         q = -((-sa + spw - 1) / spw);
                r = longint'(q) & 64'hFFFF_FFFF;
            end
            4'h8: r = ub;
            4'h9: r = (ia < ib) ? 64'd1 : 64'd0;
            4'hA: r = (ua < ub) ? 64'd1 : 64'd0;
            default: r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    // Model of the registered path, captured on the same edge as the DUT.
    logic [31:0] exp_q;
    logic        exp_q_valid = 1'b0;
    always @(posedge clk) begin
        exp_q       = rst ? 32'd0 : model(operation, in_0, in_1);
        exp_q_valid = 1'b1;
    end

    // Compare process: outputs sampled on the falling edge every cycle.
    always @(negedge clk) begin
        if (exp_q_valid) begin
            check("model_out",    out,             model(operation, in_0, in_1));
            check("model_zero",   {31'b0, zero},   {31'b0, model(operation, in_0, in_1) == 32'd0});
            check("model_out_q",  out_q,           exp_q);
            check("model_zero_q", {31'b0, zero_q}, {31'b0, exp_q == 32'd0});
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst       = 1'b1;
        in_0      = 32'd0;
        in_1      = 32'd0;
        operation = 4'h0;

        // Reset edge clears the registered path.
        @(negedge clk);
        check("rst_out_q",  out_q,           32'd0);
        check("rst_zero_q", {31'b0, zero_q}, 32'd1);

        // Release reset and apply ADD 5+7; registered copy lags by one edge.
        @(posedge clk); #1;
        rst = 1'b0; operation = 4'h0; in_0 = 32'd5; in_1 = 32'd7;
        @(negedge clk);
        check("add_out_comb",    out,   32'd12);
        check("add_out_q_early", out_q, 32'd0);
        @(negedge clk);
        check("add_out_q",  out_q,           32'd12);
        check("add_zero_q", {31'b0, zero_q}, 32'd0);

        // Mid-stream reset with inputs held: only the registered path clears.
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pre_out_q", out_q, 32'd12);
        @(negedge clk);
        check("midrst_out_q",  out_q,           32'd0);
        check("midrst_zero_q", {31'b0, zero_q}, 32'd1);
        check("midrst_out",    out,             32'd12);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs = '{
            '{"add_5_7",     4'h0, 32'd5,          32'd7,          32'd12},
            '{"add_m2_7",    4'h0, 32'hFFFF_FFFE,  32'd7,          32'd5},
            '{"sub_5_7",     4'h1, 32'd5,          32'd7,          32'hFFFF_FFFE},
            '{"sub_m2_m7",   4'h1, 32'hFFFF_FFFE,  32'hFFFF_FFF9,  32'd5},
            '{"sub_15_0",    4'h1, 32'd15,         32'd0,          32'd15},
            '{"sub_9_9",     4'h1, 32'd9,          32'd9,          32'd0},
            '{"xor_5_6",     4'h2, 32'd5,          32'd6,          32'd3},
            '{"xor_10_3",    4'h2, 32'd10,         32'd3,          32'd9},
            '{"or_10_3",     4'h3, 32'd10,         32'd3,          32'd11},
            '{"or_11_m11",   4'h3, 32'd11,         32'hFFFF_FFF5,  32'hFFFF_FFFF},
            '{"and_10_3",    4'h4, 32'd10,         32'd3,          32'd2},
            '{"pass_8_14",   4'h8, 32'd8,          32'd14,         32'd14},
            '{"lsr_10_3",    4'h5, 32'd10,         32'd3,          32'd1},
            '{"lsr_ones_3",  4'h5, 32'hFFFF_FFFF,  32'd3,          32'h1FFF_FFFF},
            '{"lsl_5_3",     4'h6, 32'd5,          32'd3,          32'd40},
            '{"asr_10_3",    4'h7, 32'd10,         32'd3,          32'd1},
            '{"asr_m10_3",   4'h7, 32'hFFFF_FFF6,  32'd3,          32'hFFFF_FFFE},
            '{"asr_m1_37",   4'h7, 32'hFFFF_FFFF,  32'd37,         32'hFFFF_FFFF},
            '{"lsr_ones_37", 4'h5, 32'hFFFF_FFFF,  32'd37,         32'h07FF_FFFF},
            '{"lsl_1_32",    4'h6, 32'd1,          32'd32,         32'd1},
            '{"slt_m1_1",    4'h9, 32'hFFFF_FFFF,  32'd1,          32'd1},
            '{"sltu_m1_1",   4'hA, 32'hFFFF_FFFF,  32'd1,          32'd0},
            '{"sltu_1_m1",   4'hA, 32'd1,          32'hFFFF_FFFF,  32'd1},
            '{"slt_3_3",     4'h9, 32'd3,          32'd3,          32'd0},
            '{"rsv_f",       4'hF, 32'hDEAD_BEEF,  32'h1234_5678,  32'd0},
            '{"rsv_b",       4'hB, 32'd5,          32'd7,          32'd0}
        };

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            operation = vecs[i].op;
            in_0      = vecs[i].a;
            in_1      = vecs[i].b;
            @(negedge clk);
            check({vecs[i].name, "_out"},  out,           vecs[i].exp);
            check({vecs[i].name, "_zero"}, {31'b0, zero}, {31'b0, vecs[i].exp == 32'd0});
        end

        // One extra edge so the last vector's registered copy is compared.
        @(negedge clk);
        check("last_out_q", out_q, vecs[vecs.size()-1].exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
